mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the single-issue MIPS core.
- Sequences the PC register: `pc_en` drives the fetch unit's PC-update enable.
- Also sequences the instruction-register latch, register-file write and data-memory access, and counts retired instructions.
- Sits between the instruction register (which supplies opcode/funct) and the datapath enables; the data-memory handshake is via `mem_ready`.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 15, MEM-state watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- mem_ready  in  1  data memory done (read data valid / write accepted).
- pc_en  out  1  PC <= NPC on the next rising edge.
- ir_en  out  1  instruction register load.
- reg_we  out  1  register-file write.
- dm_re  out  1  data-memory read request.
- dm_we  out  1  data-memory write request.
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- state  out  3  current state encoding (debug).
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH(0), instr_cnt=0.
  - All enables and `illegal` are forced 0 while reset is low.
  - First FETCH occurs in the first cycle after release.
  - Reset mid-operation aborts the instruction; no partial writes are issued after assertion.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5-7 are unreachable and go to FETCH with all enables 0.
- Instruction classes:
  - R: op=000000 with funct addu=100001, subu=100011, sll/nop=000000.
  - JR: op=0, funct=001000.
  - I-ALU: ori=001101, lui=001111.
  - LW=100011, SW=101011, BEQ=000100, J=000010, JAL=000011.
  - Anything else is illegal.
- Outputs are decoded combinationally from the registered state plus `op`/`funct`; in MEM they also depend on `mem_ready`. `op`/`funct` are stable from DECODE on (IR loaded in FETCH).
- FETCH: ir_en=1 -> DECODE.
- DECODE:
  - J or JR: pc_en=1 -> FETCH.
  - JAL: pc_en=1, reg_we=1 (link) -> FETCH.
  - Illegal: illegal=1, pc_en=1, no writes -> FETCH (treated as nop).
  - All other classes -> EXEC.
- EXEC:
  - R, I-ALU -> WB.
  - LW, SW -> MEM.
  - BEQ: pc_en=1 -> FETCH. The datapath selects NPC; the controller always pulses pc_en.
- MEM:
  - LW: dm_re=1 held until mem_ready=1; then -> WB.
  - SW: dm_we=1 held until mem_ready=1; in that ready cycle pc_en=1 -> FETCH.
  - mem_ready=0: stay in MEM, no pc_en.
  - mem_ready sampled 1 in the same cycle MEM is entered completes immediately (zero wait).
- WB: reg_we=1, pc_en=1 -> FETCH.
- Latency (cycles, zero memory wait): J/JR/JAL/illegal 2, BEQ 3, R/I-ALU 4, SW 4, LW 5. Each memory wait cycle adds 1.
- pc_en is asserted exactly once per instruction, in its final cycle.
- instr_cnt increments by 1 on every cycle with pc_en=1, except illegal instructions. It wraps modulo 2^CNT_W without saturation.
- reg_we and dm_we are never asserted in the same cycle; ir_en is never asserted outside FETCH.

Optional Feature:
- Macro: MC_CTRL_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on MEM entry and increments each MEM cycle with mem_ready=0.
  - When it reaches TIMEOUT, the instruction is aborted: dm_re/dm_we drop, pc_en=1, illegal=1 for one cycle, reg_we not asserted, -> FETCH, instr_cnt not incremented.
  - The counter resets to 0 asynchronously.
- Undefined: no counter; MEM waits indefinitely for mem_ready.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-LW -> all enables 0, state=0, instr_cnt=0; after release, ir_en=1 in the first cycle.
- addu (op=0, funct=100001) -> states 0,1,2,4; reg_we=1 and pc_en=1 only in cycle 4; instr_cnt 0->1.
- lw (op=100011), mem_ready low for 2 cycles -> dm_re high for 3 MEM cycles, then WB with reg_we=1, pc_en=1; total 7 cycles.
- sw (op=101011), mem_ready=1 on MEM entry -> dm_we=1 and pc_en=1 in the same cycle, reg_we never 1; total 4 cycles.
- j (000010), then jal (000011), then beq (000100) -> 2/2/3 cycles; reg_we=1 only for jal; instr_cnt ends at 3.
- op=111111 -> illegal pulse in DECODE, pc_en=1, instr_cnt unchanged. With MC_CTRL_MEM_TIMEOUT_EN, lw with mem_ready stuck at 0 -> abort after 15 wait cycles with illegal=1, no reg_we.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-issue MIPS core: sequences IR load, PC update, RF write, DM access.
// Latency: J/JR/JAL/illegal 2, BEQ 3, R/I-ALU 4, SW 4, LW 5 cycles plus one per memory wait cycle.
// Backpressure: MEM holds dm_re/dm_we until mem_ready; optional watchdog (MC_CTRL_MEM_TIMEOUT_EN) aborts after TIMEOUT waits.
module mc_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_en,
  output logic             reg_we,
  output logic             dm_re,
  output logic             dm_we,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] C_R    = 4'd0;
  localparam logic [3:0] C_JR   = 4'd1;
  localparam logic [3:0] C_IALU = 4'd2;
  localparam logic [3:0] C_LW   = 4'd3;
  localparam logic [3:0] C_SW   = 4'd4;
  localparam logic [3:0] C_BEQ  = 4'd5;
  localparam logic [3:0] C_J    = 4'd6;
  localparam logic [3:0] C_JAL  = 4'd7;
  localparam logic [3:0] C_ILL  = 4'd8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [3:0]       w_cls;
  logic             w_pc_en;
  logic             w_ir_en;
  logic             w_reg_we;
  logic             w_dm_re;
  logic             w_dm_we;
  logic             w_illegal;
  logic             w_timeout;
  logic [CNT_W-1:0] r_cnt;

  // Classify the instruction held in the IR; anything not listed is illegal.
  always_comb begin
    w_cls = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU, F_SUBU, F_SLL: w_cls = C_R;
          F_JR:                  w_cls = C_JR;
          default:               w_cls = C_ILL;
        endcase
      end
      OP_ORI, OP_LUI: w_cls = C_IALU;
      OP_LW:          w_cls = C_LW;
      OP_SW:          w_cls = C_SW;
      OP_BEQ:         w_cls = C_BEQ;
      OP_J:           w_cls = C_J;
      OP_JAL:         w_cls = C_JAL;
      default:        w_cls = C_ILL;
    endcase
  end

`ifdef MC_CTRL_MEM_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] r_wait;

  // Count consecutive not-ready MEM cycles; cleared whenever we are outside MEM so it starts at 0 on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (r_state != S_MEM) begin
      r_wait <= '0;
    end else if (!mem_ready && !w_timeout) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_MEM) && (r_wait == WAIT_W'(TIMEOUT));
`else
  // Watchdog compiled out: MEM waits for mem_ready indefinitely.
  assign w_timeout = (TIMEOUT < 0);
`endif

  // Next-state and raw enable decode from the registered state plus the instruction class.
  always_comb begin
    w_state_nxt = S_FETCH;
    w_pc_en     = 1'b0;
    w_ir_en     = 1'b0;
    w_reg_we    = 1'b0;
    w_dm_re     = 1'b0;
    w_dm_we     = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_en     = 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (w_cls)
          C_J, C_JR: begin
            w_pc_en = 1'b1;
          end
          C_JAL: begin
            w_pc_en  = 1'b1;
            w_reg_we = 1'b1;
          end
          C_ILL: begin
            // Unsupported opcode is skipped like a nop, flagged but not counted.
            w_pc_en   = 1'b1;
            w_illegal = 1'b1;
          end
          default: w_state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_cls)
          C_R, C_IALU: w_state_nxt = S_WB;
          C_LW, C_SW:  w_state_nxt = S_MEM;
          C_BEQ:       w_pc_en     = 1'b1;
          default:     w_state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (w_timeout) begin
          // Watchdog abort: drop the request, retire as an uncounted illegal.
          w_pc_en   = 1'b1;
          w_illegal = 1'b1;
        end else if (w_cls == C_LW) begin
          w_dm_re     = 1'b1;
          w_state_nxt = mem_ready ? S_WB : S_MEM;
        end else if (w_cls == C_SW) begin
          w_dm_we     = 1'b1;
          w_pc_en     = mem_ready;
          w_state_nxt = mem_ready ? S_FETCH : S_MEM;
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_pc_en  = 1'b1;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Retired-instruction counter: one per pc_en, skipping illegal/aborted, wraps freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_pc_en && !w_illegal) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Enables are forced low combinationally while reset is held.
  assign pc_en     = reset & w_pc_en;
  assign ir_en     = reset & w_ir_en;
  assign reg_we    = reset & w_reg_we;
  assign dm_re     = reset & w_dm_re;
  assign dm_we     = reset & w_dm_we;
  assign illegal   = reset & w_illegal;
  assign state     = r_state;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             pc_en;
  logic             ir_en;
  logic             reg_we;
  logic             dm_re;
  logic             dm_we;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] m_cnt;

  mc_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .ir_en     (ir_en),
    .reg_we    (reg_we),
    .dm_re     (dm_re),
    .dm_we     (dm_we),
    .illegal   (illegal),
    .state     (state),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {K_R, K_JR, K_IALU, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL} kind_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    int         waits;
    int         exp_cycles;
    int         exp_inc;
  } vec_t;

  function automatic kind_t kind_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f == 6'h21 || f == 6'h23 || f == 6'h00) return K_R;
      if (f == 6'h08) return K_JR;
      return K_ILL;
    end
    if (o == 6'h0D || o == 6'h0F) return K_IALU;
    if (o == 6'h23) return K_LW;
    if (o == 6'h2B) return K_SW;
    if (o == 6'h04) return K_BEQ;
    if (o == 6'h02) return K_J;
    if (o == 6'h03) return K_JAL;
    return K_ILL;
  endfunction

  function automatic bit aborted(input kind_t c, input int waits);
`ifdef MC_CTRL_MEM_TIMEOUT_EN
    return (c == K_LW || c == K_SW) && (waits >= TIMEOUT);
`else
    return (c == K_LW || c == K_SW) && (waits < 0);
`endif
  endfunction

  // Number of cycles spent in MEM for a memory instruction.
  function automatic int mem_cycles(input kind_t c, input int waits);
    if (c != K_LW && c != K_SW) return 0;
    if (aborted(c, waits)) return TIMEOUT + 1;
    return waits + 1;
  endfunction

  function automatic int instr_len(input kind_t c, input int waits);
    int m;
    m = mem_cycles(c, waits);
    case (c)
      K_J, K_JR, K_JAL, K_ILL: return 2;
      K_BEQ:                   return 3;
      K_R, K_IALU:             return 4;
      K_SW:                    return 3 + m;
      K_LW:                    return aborted(c, waits) ? 3 + m : 4 + m;
      default:                 return 2;
    endcase
  endfunction

  // Expected {state, pc_en, ir_en, reg_we, dm_re, dm_we, illegal} in cycle k of an instruction.
  function automatic logic [8:0] exp_vec(input kind_t c, input int waits, input int k);
    int         len;
    int         m;
    bit         ab;
    bit         last;
    logic [2:0] st;
    logic       rw;
    logic       dre;
    logic       dwe;
    logic       ill;
    len = instr_len(c, waits);
    m   = mem_cycles(c, waits);
    ab  = aborted(c, waits);
    if (k >= len) return 9'b000_0_1_0000;
    if (k < 3)          st = 3'(k);
    else if (k < 3 + m) st = 3'd3;
    else                st = 3'd4;
    last = (k == len - 1);
    rw   = last && !ab && (c == K_R || c == K_IALU || c == K_JAL || c == K_LW);
    dre  = (c == K_LW) && (st == 3'd3) && !(ab && last);
    dwe  = (c == K_SW) && (st == 3'd3) && !(ab && last);
    ill  = last && (c == K_ILL || ab);
    return {st, last, (k == 0), rw, dre, dwe, ill};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {state, pc_en, ir_en, reg_we, dm_re, dm_we, illegal};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one instruction, checking every cycle; stops on pc_en or after max_cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int waits,
                           input int max_cycles, output int cycles);
    kind_t c;
    int    k;
    bit    done;
    c    = kind_of(o, f);
    k    = 0;
    done = 1'b0;
    while (!done && k < max_cycles) begin
      @(negedge clk);
      op        = o;
      funct     = f;
      mem_ready = (k >= 3) ? (k >= 3 + waits) : 1'($urandom);
      #1;
      check($sformatf("cyc%0d op%0h fn%0h", k, o, f), 64'(dut_vec()), 64'(exp_vec(c, waits, k)));
      if (pc_en) done = 1'b1;
      k++;
    end
    cycles = k;
    if (done) begin
      @(posedge clk);
      #1;
      if (c != K_ILL && !aborted(c, waits)) m_cnt = m_cnt + 1'b1;
      check("instr_cnt", 64'(instr_cnt), 64'(m_cnt));
    end
  endtask

  vec_t             tbl[$];
  int               cyc;
  logic [CNT_W-1:0] cb;
  logic [5:0]       op_pool[10];
  logic [5:0]       fn_pool[5];

  initial begin
    reset     = 1'b0;
    op        = 6'h00;
    funct     = 6'h00;
    mem_ready = 1'b0;
    m_cnt     = '0;

    tbl.push_back('{6'h00, 6'h21, 0,  4, 1});  // addu
    tbl.push_back('{6'h00, 6'h23, 1,  4, 1});  // subu
    tbl.push_back('{6'h00, 6'h00, 0,  4, 1});  // sll/nop
    tbl.push_back('{6'h00, 6'h08, 0,  2, 1});  // jr
    tbl.push_back('{6'h0D, 6'h00, 0,  4, 1});  // ori
    tbl.push_back('{6'h0F, 6'h15, 0,  4, 1});  // lui
    tbl.push_back('{6'h23, 6'h00, 2,  7, 1});  // lw, 2 wait cycles
    tbl.push_back('{6'h2B, 6'h00, 0,  4, 1});  // sw, zero wait
    tbl.push_back('{6'h02, 6'h00, 0,  2, 1});  // j
    tbl.push_back('{6'h03, 6'h00, 0,  2, 1});  // jal
    tbl.push_back('{6'h04, 6'h00, 0,  3, 1});  // beq
    tbl.push_back('{6'h3F, 6'h00, 0,  2, 0});  // illegal opcode
    tbl.push_back('{6'h00, 6'h3F, 0,  2, 0});  // illegal funct
    tbl.push_back('{6'h23, 6'h00, 0,  5, 1});  // lw, zero wait
    tbl.push_back('{6'h2B, 6'h00, 3,  7, 1});  // sw, 3 wait cycles

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", 64'(dut_vec()), 64'd0);
    check("reset instr_cnt", 64'(instr_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table-driven instruction vectors
    foreach (tbl[i]) begin
      cb = m_cnt;
      run_instr(tbl[i].op, tbl[i].funct, tbl[i].waits, 40, cyc);
      check($sformatf("latency[%0d]", i), 64'(cyc), 64'(tbl[i].exp_cycles));
      check($sformatf("cnt_inc[%0d]", i), 64'(instr_cnt), 64'(cb + CNT_W'(tbl[i].exp_inc)));
    end

    // Reset held for 3 cycles in the middle of a waiting LW
    run_instr(6'h02, 6'h00, 0, 40, cyc);
    run_instr(6'h23, 6'h00, 8, 5, cyc);
    @(negedge clk);
    reset = 1'b0;
    m_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("midlw reset outputs %0d", i), 64'(dut_vec()), 64'd0);
      check($sformatf("midlw reset cnt %0d", i), 64'(instr_cnt), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(6'h00, 6'h21, 0, 40, cyc);
    check("post-reset addu latency", 64'(cyc), 64'd4);
    check("post-reset cnt", 64'(instr_cnt), 64'd1);

`ifdef MC_CTRL_MEM_TIMEOUT_EN
    // Watchdog: just under the limit completes, at/over the limit aborts uncounted.
    cb = m_cnt;
    run_instr(6'h23, 6'h00, 14, 40, cyc);
    check("lw 14 waits latency", 64'(cyc), 64'd19);
    check("lw 14 waits cnt", 64'(instr_cnt), 64'(cb + 1'b1));
    cb = m_cnt;
    run_instr(6'h23, 6'h00, 1000, 40, cyc);
    check("lw timeout latency", 64'(cyc), 64'd19);
    check("lw timeout cnt", 64'(instr_cnt), 64'(cb));
    run_instr(6'h2B, 6'h00, 1000, 40, cyc);
    check("sw timeout latency", 64'(cyc), 64'd19);
    check("sw timeout cnt", 64'(instr_cnt), 64'(cb));
`endif

    // Randomized instruction stream against the model
    op_pool = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
    fn_pool = '{6'h21, 6'h23, 6'h00, 6'h08, 6'h2A};
    for (int n = 0; n < 300; n++) begin
      logic [5:0] ro;
      logic [5:0] rf;
      int         rw;
      ro = ($urandom_range(0, 9) == 9) ? 6'($urandom) : op_pool[$urandom_range(0, 9)];
      rf = ($urandom_range(0, 7) == 7) ? 6'($urandom) : fn_pool[$urandom_range(0, 4)];
      rw = int'($urandom_range(0, 3));
      run_instr(ro, rf, rw, 40, cyc);
      check($sformatf("rand latency %0d", n), 64'(cyc), 64'(instr_len(kind_of(ro, rf), rw)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
